// File: rtl/mem_fu_pipe.sv
// Load/store functional unit: issue FIFO feeding a single-outstanding data-memory
// request FSM with lane alignment, load extension and an RVFI-style writeback record.
module mem_fu_pipe #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_is_store,
    input  logic [2:0]       issue_funct3,
    input  logic [31:0]      issue_base,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_wdata,
    input  logic [TAG_W-1:0] issue_tag,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_rmask,
    output logic [3:0]       dmem_wmask,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_resp,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_rdata,
    output logic             wb_misaligned,
    output logic [31:0]      wb_addr,
    output logic [3:0]       wb_rmask,
    output logic [3:0]       wb_wmask,
    output logic [31:0]      wb_wdata,
    output logic [31:0]      wb_mrdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             is_store;
        logic [2:0]       funct3;
        logic [31:0]      ea;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } q_entry_t;

    typedef struct packed {
        logic             is_store;
        logic [2:0]       funct3;
        logic [1:0]       off;
        logic [31:0]      addr;
        logic [3:0]       mask;
        logic [31:0]      wdata;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, REQ, WB, DRAIN} state_t;

    state_t state, state_next;

    q_entry_t         q_mem [DEPTH];
    q_entry_t         issue_entry;
    q_entry_t         head_e;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             push, pop, q_nonempty;

    req_t        req, head_req;
    logic        head_mis;
    logic        load_req, load_wb_mis, load_wb_resp;
    logic [31:0] lane, load_result;

    // Issue queue: circular FIFO, flush empties it and swallows a same-cycle issue
    assign issue_ready = (count < CNT_W'(DEPTH)) && !rst;
    assign push        = issue_valid && issue_ready && !flush;
    assign q_nonempty  = (count != '0);
    assign head_e      = q_mem[head];

    always_comb begin
        issue_entry          = '0;
        issue_entry.is_store = issue_is_store;
        issue_entry.funct3   = issue_funct3;
        issue_entry.ea       = issue_base + issue_imm;
        issue_entry.wdata    = issue_wdata;
        issue_entry.tag      = issue_tag;
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[tail] <= issue_entry;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Decode the queue head into an aligned request (masks, lane-placed store data)
    always_comb begin
        head_req          = '0;
        head_req.is_store = head_e.is_store;
        head_req.funct3   = head_e.funct3;
        head_req.off      = head_e.ea[1:0];
        head_req.addr     = {head_e.ea[31:2], 2'b00};
        head_req.tag      = head_e.tag;
        head_mis          = 1'b0;
        case (head_e.funct3[1:0])
            2'b00: begin
                head_req.mask  = 4'b0001 << head_e.ea[1:0];
                head_req.wdata = 32'(head_e.wdata[7:0]) << {head_e.ea[1:0], 3'b000};
            end
            2'b01: begin
                head_req.mask  = 4'b0011 << head_e.ea[1:0];
                head_req.wdata = 32'(head_e.wdata[15:0]) << {head_e.ea[1:0], 3'b000};
                head_mis       = head_e.ea[0];
            end
            default: begin
                head_req.mask  = 4'b1111;
                head_req.wdata = head_e.wdata;
                head_mis       = (head_e.ea[1:0] != 2'b00);
            end
        endcase
        if (!head_e.is_store) head_req.wdata = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        load_req     = 1'b0;
        load_wb_mis  = 1'b0;
        load_wb_resp = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && q_nonempty) begin
                    pop = 1'b1;
                    if (head_mis) begin
                        load_wb_mis = 1'b1;
                        state_next  = WB;
                    end else begin
                        load_req   = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // A flush that coincides with the response needs no drain: the access is done
                if (flush) begin
                    state_next = dmem_resp ? IDLE : DRAIN;
                end else if (dmem_resp) begin
                    load_wb_resp = 1'b1;
                    state_next   = WB;
                end
            end
            WB: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (wb_ready) begin
                    if (q_nonempty && !head_mis) begin
                        pop        = 1'b1;
                        load_req   = 1'b1;
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (dmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Select and extend the addressed lane of the returned word
    always_comb begin
        lane = dmem_rdata >> {req.off, 3'b000};
        case (req.funct3)
            3'b000:  load_result = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_result = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_result = 32'(lane[7:0]);
            3'b101:  load_result = 32'(lane[15:0]);
            default: load_result = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req           <= '0;
            wb_tag        <= '0;
            wb_rdata      <= '0;
            wb_misaligned <= 1'b0;
            wb_addr       <= '0;
            wb_rmask      <= '0;
            wb_wmask      <= '0;
            wb_wdata      <= '0;
            wb_mrdata     <= '0;
        end else begin
            if (load_req) req <= head_req;
            if (load_wb_mis) begin
                wb_tag        <= head_e.tag;
                wb_rdata      <= '0;
                wb_misaligned <= 1'b1;
                wb_addr       <= head_req.addr;
                wb_rmask      <= '0;
                wb_wmask      <= '0;
                wb_wdata      <= '0;
                wb_mrdata     <= '0;
            end else if (load_wb_resp) begin
                wb_tag        <= req.tag;
                wb_rdata      <= req.is_store ? 32'd0 : load_result;
                wb_misaligned <= 1'b0;
                wb_addr       <= req.addr;
                wb_rmask      <= req.is_store ? 4'd0 : req.mask;
                wb_wmask      <= req.is_store ? req.mask : 4'd0;
                wb_wdata      <= req.wdata;
                wb_mrdata     <= req.is_store ? 32'd0 : dmem_rdata;
            end
        end
    end

    // Memory port is live only while a request is outstanding; reset kills it at once
    always_comb begin
        dmem_addr  = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
        dmem_wdata = '0;
        if (!rst && (state == REQ || state == DRAIN)) begin
            dmem_addr  = req.addr;
            dmem_rmask = req.is_store ? 4'd0 : req.mask;
            dmem_wmask = req.is_store ? req.mask : 4'd0;
            dmem_wdata = req.wdata;
        end
    end

    assign wb_valid = (state == WB) && !rst;

endmodule

// File: tb/tb_mem_fu_pipe.sv
// Directed self-checking bench for mem_fu_pipe with hand-computed expectations.
module tb_mem_fu_pipe;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic             issue_valid, issue_ready, issue_is_store;
    logic [2:0]       issue_funct3;
    logic [31:0]      issue_base, issue_imm, issue_wdata;
    logic [TAG_W-1:0] issue_tag;
    logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]       dmem_rmask, dmem_wmask;
    logic             dmem_resp;
    logic             wb_valid, wb_ready, wb_misaligned;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_rdata, wb_addr, wb_wdata, wb_mrdata;
    logic [3:0]       wb_rmask, wb_wmask;

    int errors = 0;
    int checks = 0;

    mem_fu_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
        .issue_base(issue_base), .issue_imm(issue_imm), .issue_wdata(issue_wdata),
        .issue_tag(issue_tag),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_rdata(wb_rdata),
        .wb_misaligned(wb_misaligned), .wb_addr(wb_addr), .wb_rmask(wb_rmask),
        .wb_wmask(wb_wmask), .wb_wdata(wb_wdata), .wb_mrdata(wb_mrdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
        issue_valid    = 1'b1;
        issue_is_store = st;
        issue_funct3   = f3;
        issue_base     = base;
        issue_imm      = imm;
        issue_wdata    = wd;
        issue_tag      = tg;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_is_store = 1'b0;
        issue_funct3 = 3'd0; issue_base = '0; issue_imm = '0; issue_wdata = '0;
        issue_tag = '0; dmem_rdata = '0; dmem_resp = 1'b0; wb_ready = 1'b1;
        tick(); tick();

        // Reset state
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_dmem_rmask", 32'(dmem_rmask), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_wb_tag", 32'(wb_tag), 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_issue_ready", 32'(issue_ready), 32'd1);

        // lb at EA 0x1003, minimum latency
        set_op(1'b0, 3'b000, 32'h1000, 32'd3, 32'd0, 6'd5);
        dmem_rdata = 32'h80FF_FFFF;
        tick();
        issue_valid = 1'b0;
        check("lb_idle_rmask", 32'(dmem_rmask), 32'd0);
        tick();
        check("lb_rmask", 32'(dmem_rmask), 32'b1000);
        check("lb_wmask", 32'(dmem_wmask), 32'd0);
        check("lb_addr", dmem_addr, 32'h1000);
        check("lb_no_wb_yet", 32'(wb_valid), 32'd0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("lb_wb_valid", 32'(wb_valid), 32'd1);
        check("lb_wb_tag", 32'(wb_tag), 32'd5);
        check("lb_wb_rdata", wb_rdata, 32'hFFFF_FF80);
        check("lb_wb_mis", 32'(wb_misaligned), 32'd0);
        check("lb_wb_rmask", 32'(wb_rmask), 32'b1000);
        check("lb_wb_addr", wb_addr, 32'h1000);
        check("lb_wb_mrdata", wb_mrdata, 32'h80FF_FFFF);
        check("lb_wb_dmem_idle", 32'(dmem_rmask), 32'd0);
        tick();
        check("lb_wb_done", 32'(wb_valid), 32'd0);

        // sh at EA 0x2002
        set_op(1'b1, 3'b001, 32'h2002, 32'd0, 32'h1234_ABCD, 6'd9);
        tick();
        issue_valid = 1'b0;
        tick();
        check("sh_wmask", 32'(dmem_wmask), 32'b1100);
        check("sh_rmask", 32'(dmem_rmask), 32'd0);
        check("sh_wdata", dmem_wdata, 32'hABCD_0000);
        check("sh_addr", dmem_addr, 32'h2000);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("sh_wb_valid", 32'(wb_valid), 32'd1);
        check("sh_wb_rdata", wb_rdata, 32'd0);
        check("sh_wb_wmask", 32'(wb_wmask), 32'b1100);
        check("sh_wb_wdata", wb_wdata, 32'hABCD_0000);
        check("sh_wb_tag", 32'(wb_tag), 32'd9);
        tick();

        // Misaligned lw at EA 0x3001 skips the memory port
        set_op(1'b0, 3'b010, 32'h3000, 32'd1, 32'd0, 6'd12);
        tick();
        issue_valid = 1'b0;
        check("mis_idle_rmask", 32'(dmem_rmask), 32'd0);
        tick();
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_flag", 32'(wb_misaligned), 32'd1);
        check("mis_rdata", wb_rdata, 32'd0);
        check("mis_wb_rmask", 32'(wb_rmask), 32'd0);
        check("mis_dmem_rmask", 32'(dmem_rmask), 32'd0);
        check("mis_tag", 32'(wb_tag), 32'd12);
        tick();
        check("mis_done", 32'(wb_valid), 32'd0);

        // Fill: five aligned lw with memory stalled, sixth must be refused
        for (int i = 0; i < 5; i++) begin
            set_op(1'b0, 3'b010, 32'h100 * i, 32'd0, 32'd0, TAG_W'(20 + i));
            tick();
        end
        set_op(1'b0, 3'b010, 32'h900, 32'd0, 32'd0, 6'd63);
        check("full_ready0", 32'(issue_ready), 32'd0);
        tick();
        check("full_ready1", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_rmask", 32'(dmem_rmask), 32'b1111);
            check("fill_addr", dmem_addr, 32'h100 * i);
            dmem_rdata = 32'hC0DE_0000 + i;
            dmem_resp  = 1'b1;
            tick();
            dmem_resp = 1'b0;
            check("fill_wb_valid", 32'(wb_valid), 32'd1);
            check("fill_wb_tag", 32'(wb_tag), 32'(20 + i));
            check("fill_wb_rdata", wb_rdata, 32'hC0DE_0000 + i);
            tick();
        end
        check("fill_empty_valid", 32'(wb_valid), 32'd0);
        check("fill_empty_rmask", 32'(dmem_rmask), 32'd0);
        check("fill_empty_ready", 32'(issue_ready), 32'd1);

        // Flush during REQ with two ops queued
        for (int i = 0; i < 3; i++) begin
            set_op(1'b0, 3'b010, 32'h500 + 32'h10 * i, 32'd0, 32'd0, TAG_W'(40 + i));
            tick();
        end
        set_op(1'b0, 3'b010, 32'h580, 32'd0, 32'd0, 6'd43);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        check("drain_rmask", 32'(dmem_rmask), 32'b1111);
        check("drain_addr", dmem_addr, 32'h500);
        check("drain_ready", 32'(issue_ready), 32'd1);
        tick();
        check("drain_hold", dmem_addr, 32'h500);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("drain_no_wb", 32'(wb_valid), 32'd0);
        check("drain_idle_rmask", 32'(dmem_rmask), 32'd0);
        tick(); tick();
        check("flush_empty_wb", 32'(wb_valid), 32'd0);
        check("flush_empty_rmask", 32'(dmem_rmask), 32'd0);

        // wb_ready held low: result stable while queue fills behind it
        wb_ready = 1'b0;
        set_op(1'b0, 3'b100, 32'h600, 32'd1, 32'd0, 6'd50);
        dmem_rdata = 32'h0000_9F00;
        tick();
        issue_valid = 1'b0;
        tick();
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("stall_wb_valid", 32'(wb_valid), 32'd1);
            check("stall_wb_rdata", wb_rdata, 32'h0000_009F);
            check("stall_wb_tag", 32'(wb_tag), 32'd50);
            check("stall_dmem_rmask", 32'(dmem_rmask), 32'd0);
            check("stall_issue_ready", 32'(issue_ready), (j < 4) ? 32'd1 : 32'd0);
            set_op(1'b0, 3'b010, 32'h700 + 32'd4 * j, 32'd0, 32'd0, TAG_W'(51 + j));
            tick();
        end
        issue_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        check("next_req_addr", dmem_addr, 32'h700);
        check("next_req_rmask", 32'(dmem_rmask), 32'b1111);

        // Reset mid-request: port drops at once, late response ignored
        rst = 1'b1;
        #1;
        check("rst_mid_rmask", 32'(dmem_rmask), 32'd0);
        check("rst_mid_ready", 32'(issue_ready), 32'd0);
        tick();
        rst = 1'b0;
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("late_resp_wb", 32'(wb_valid), 32'd0);
        check("late_resp_rmask", 32'(dmem_rmask), 32'd0);
        check("late_resp_tag", 32'(wb_tag), 32'd0);
        check("late_resp_ready", 32'(issue_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
